// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, requester
// identity and the default fetch-starvation bound.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with a
// single outstanding request/grant/response transaction at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_e              state_q;
  owner_e              owner_q;
  logic                kill_q;
  logic [CNT_W-1:0]    starve_q;
  logic [CNT_W-1:0]    starve_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic                mem_req_q;
  logic                busy_q;
  logic                grant_data;
  logic                grant_if;

  // Arbitration pick: data wins unless the waiting fetch has been starved too long.
  always_comb begin
    grant_data = 1'b0;
    grant_if   = 1'b0;
    starve_d   = starve_q;
    if (state_q == ST_IDLE) begin
      grant_data = d_req && (!if_req || (starve_q < STARVE_LIM));
      grant_if   = !grant_data && if_req;
    end else begin
      grant_data = 1'b0;
      grant_if   = 1'b0;
    end
    if (!if_req || grant_if) begin
      starve_d = '0;
    end else if (grant_data && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Transaction sequencer: latch request, hold it until granted, await response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      kill_q    <= 1'b0;
      starve_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        ST_IDLE: begin
          kill_q <= 1'b0;
          if (grant_data) begin
            owner_q   <= OWN_D;
            addr_q    <= d_addr;
            we_q      <= d_we;
            wdata_q   <= d_wdata;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_REQ;
          end else if (grant_if) begin
            owner_q   <= OWN_IF;
            addr_q    <= if_addr;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_REQ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (owner_q == OWN_IF && if_flush) begin
            kill_q <= 1'b1;
          end
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_WAIT;
          end else begin
            state_q <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            kill_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (owner_q == OWN_IF && if_flush) begin
            kill_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          kill_q    <= 1'b0;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Completion pulses follow the response in the same cycle; a killed fetch is dropped.
  always_comb begin
    d_ready  = (state_q == ST_WAIT) && mem_rvalid && (owner_q == OWN_D);
    if_ready = (state_q == ST_WAIT) && mem_rvalid && (owner_q == OWN_IF)
               && !kill_q && !if_flush;
  end

  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, if_ready;
  logic [31:0] if_addr = 32'h0, if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_ready;
  logic [31:0] d_addr = 32'h0, d_wdata = 32'h0, d_rdata;
  logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Reference model: one pending transaction, who owns it, whether memory accepted it.
  bit          m_active = 1'b0, m_acc = 1'b0, m_own_d = 1'b0, m_kill = 1'b0;
  int          m_starve = 0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
  logic        m_we = 1'b0;

  // Memory responder configuration and per-phase cycle counter.
  int  cfg_gnt = 0, cfg_rv = 0, mem_cnt = 0;
  bit  cfg_rand = 1'b0, cfg_fixed = 1'b0, force_rv = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;

  // Observations of the DUT.
  int          cyc = 0, if_rdy_n = 0, d_rdy_n = 0, if_rdy_cyc = 0, d_rdy_cyc = 0, req_rise_cyc = 0;
  logic [31:0] if_rdy_data = 32'h0;
  logic        prev_req = 1'b0;
  logic [31:0] grant_q[$];
  bit          e_if = 1'b0, e_d = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    bit gd, gi, p_act, p_acc;
    mem_gnt    = m_active && !m_acc && (mem_cnt >= cfg_gnt);
    mem_rvalid = (m_active && m_acc && (mem_cnt >= cfg_rv)) || force_rv
                 || (!m_active && cfg_rand && ($urandom_range(0, 7) == 0));
    mem_rdata  = cfg_fixed ? cfg_rdata : $urandom;
    #1;
    e_d  = m_active && m_acc && mem_rvalid && m_own_d;
    e_if = m_active && m_acc && mem_rvalid && !m_own_d && !m_kill && !if_flush;
    chk("mem_req", mem_req, m_active && !m_acc);
    chk("busy", busy, m_active);
    chk("d_ready", d_ready, e_d);
    chk("if_ready", if_ready, e_if);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_we", mem_we, m_we);
    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    if (e_if) chk("if_rdata", if_rdata, mem_rdata);
    if (e_d) chk("d_rdata", d_rdata, mem_rdata);
    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
      grant_q.push_back(mem_addr);
      req_rise_cyc = cyc;
    end
    prev_req = mem_req;
    if (if_ready === 1'b1) begin if_rdy_n++; if_rdy_cyc = cyc; if_rdy_data = if_rdata; end
    if (d_ready === 1'b1) begin d_rdy_n++; d_rdy_cyc = cyc; end
    p_act = m_active;
    p_acc = m_acc;
    if (reset) begin
      m_active = 1'b0; m_acc = 1'b0; m_own_d = 1'b0; m_kill = 1'b0; m_starve = 0;
      m_addr = 32'h0; m_we = 1'b0; m_wdata = 32'h0;
    end else begin
      gd = 1'b0;
      gi = 1'b0;
      if (!m_active) begin
        if (d_req && (!if_req || m_starve < STARVE)) gd = 1'b1;
        else if (if_req) gi = 1'b1;
        if (gd) begin m_own_d = 1'b1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_active = 1'b1; end
        if (gi) begin m_own_d = 1'b0; m_addr = if_addr; m_we = 1'b0; m_wdata = 32'h0; m_active = 1'b1; end
      end else if (!m_acc) begin
        if (!m_own_d && if_flush) m_kill = 1'b1;
        if (mem_gnt) m_acc = 1'b1;
      end else begin
        if (!m_own_d && if_flush) m_kill = 1'b1;
        if (mem_rvalid) begin m_active = 1'b0; m_acc = 1'b0; m_kill = 1'b0; end
      end
      if (!if_req || gi) m_starve = 0;
      else if (gd && m_starve < STARVE) m_starve++;
    end
    if (p_act != m_active || p_acc != m_acc) begin
      mem_cnt = 0;
      if (cfg_rand && !m_active) begin
        cfg_gnt = $urandom_range(0, 3);
        cfg_rv  = $urandom_range(0, 3);
      end
    end else mem_cnt++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_quiet(input int budget);
    int n = 0;
    while ((if_req || d_req || m_active) && n < budget) begin
      step();
      n++;
      if (e_if) if_req = 1'b0;
      if (e_d) d_req = 1'b0;
    end
    chk("quiet_within_budget", (n < budget), 1'b1);
  endtask

  task automatic clear_obs();
    grant_q.delete();
    if_rdy_n = 0;
    d_rdy_n  = 0;
  endtask

  initial begin
    int t0, k, ifn;
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_addr", mem_addr, 32'h0);

    // Fetch only, immediate grant, response one cycle later.
    clear_obs();
    cfg_gnt = 0; cfg_rv = 0; cfg_fixed = 1'b1; cfg_rdata = 32'h00500093;
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    run_until_quiet(20);
    chk("fetch_req_latency", req_rise_cyc - t0, 1);
    chk("fetch_ready_latency", if_rdy_cyc - t0, 2);
    chk("fetch_rdata", if_rdy_data, 32'h00500093);
    cfg_fixed = 1'b0;

    // Simultaneous fetch and load: data goes first.
    clear_obs();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    run_until_quiet(30);
    chk("simul_first_addr", grant_q.size() > 0 ? grant_q[0] : 32'hx, 32'h2000);
    chk("simul_second_addr", grant_q.size() > 1 ? grant_q[1] : 32'hx, 32'h100);
    chk("simul_d_before_if", (d_rdy_cyc < if_rdy_cyc), 1'b1);

    // Starvation: fetch held while six loads stream in.
    clear_obs();
    if_req = 1'b1; if_addr = 32'h100; ifn = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; k = 0;
    for (int n = 0; n < 120 && (if_req || d_req || m_active); n++) begin
      step();
      if (e_d) begin
        k++;
        if (k < 6) d_addr = 32'h4000 + 32'(4 * k);
        else d_req = 1'b0;
      end
      if (e_if) begin
        ifn++;
        if (ifn >= 2) if_req = 1'b0;
        else if_addr = 32'h180;
      end
    end
    chk("starve_grant_count", grant_q.size(), 8);
    if (grant_q.size() == 8) begin
      chk("starve_g3", grant_q[3], 32'h400c);
      chk("starve_g4_if", grant_q[4], 32'h100);
      chk("starve_g5_d_resumes", grant_q[5], 32'h4010);
      chk("starve_g7", grant_q[7], 32'h180);
    end

    // Flush while the fetch waits for its grant.
    clear_obs();
    cfg_gnt = 3; cfg_rv = 0;
    if_req = 1'b1; if_addr = 32'h100;
    step();
    if_flush = 1'b1; if_req = 1'b0;
    step();
    if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h200;
    run_until_quiet(40);
    chk("flush_ready_count", if_rdy_n, 1);
    chk("flush_next_addr", grant_q.size() > 1 ? grant_q[1] : 32'hx, 32'h200);

    // Store with a delayed grant.
    clear_obs();
    cfg_gnt = 2; cfg_rv = 1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF;
    run_until_quiet(30);
    chk("store_ready_count", d_rdy_n, 1);
    d_we = 1'b0;

    // Reset while waiting for the response, then a stray response.
    clear_obs();
    cfg_gnt = 0; cfg_rv = 5;
    d_req = 1'b1; d_addr = 32'h5000;
    step(); step(); step();
    reset = 1'b1; d_req = 1'b0;
    step();
    reset = 1'b0; force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    chk("rst_wait_busy", busy, 1'b0);
    chk("rst_wait_no_ready", if_rdy_n + d_rdy_n, 0);
    cfg_rv = 0;
    if_req = 1'b1; if_addr = 32'h100;
    run_until_quiet(20);
    chk("rst_wait_next_served", if_rdy_n, 1);

    // Random traffic with random memory timing and stray responses while idle.
    cfg_rand = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if_flush = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = {$urandom_range(0, 255), 2'b00};
      end else if (if_req && $urandom_range(0, 15) == 0) begin
        if_flush = 1'b1; if_req = 1'b0;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom;
      end
      step();
      if (e_if) if_req = 1'b0;
      if (e_d) d_req = 1'b0;
    end
    if_flush = 1'b0;
    run_until_quiet(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
